// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared types for the MIPS32 memory arbiter slice.
//   mode_e    : arbiter operating mode (LOAD/RUN/HALT), also driven on `mode`
//   req_id_e  : requester identity, used to steer the delayed read-valid pulse
// -----------------------------------------------------------------------------
package mips32_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    REQ_LD = 2'd0,
    REQ_IF = 2'd1,
    REQ_DM = 2'd2
  } req_id_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter_if
// Bundles every bus between the arbiter, its three requesters (program loader,
// instruction fetch, data access), the core status lines and the memory array.
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters, core, memory)
// Parameters: AW word-address width, DW data width.
// -----------------------------------------------------------------------------
interface mips32_mem_arbiter_if
  import mips32_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
);

  // Loader
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_done;
  logic          ld_gnt;
  logic          ld_rvalid;
  // Instruction fetch (read only)
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  // Data access
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  // Core status / shared read data / mode
  logic          halted;
  logic [DW-1:0] rdata;
  mode_e         mode;
  // Memory command port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    output ld_gnt, ld_rvalid,
    input  if_req, if_addr,
    output if_gnt, if_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid,
    input  halted,
    output rdata, mode,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    input  ld_gnt, ld_rvalid,
    output if_req, if_addr,
    input  if_gnt, if_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid,
    output halted,
    input  rdata, mode,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mips32_starve_cnt.sv
// -----------------------------------------------------------------------------
// mips32_starve_cnt
// Saturating count of consecutive cycles the fetch requester was denied.
//   clk, reset : clock, asynchronous active-high reset
//   inc_i      : fetch requested and was not granted this cycle
//   clr_i      : fetch granted, or arbiter is leaving/outside RUN (wins over inc)
//   at_max_o   : count has reached MAX_WAIT; fetch gets priority over data
// -----------------------------------------------------------------------------
module mips32_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
// Shares one synchronous single-port memory (1-cycle read latency) between the
// program loader, instruction fetch and data access of the MIPS32 core.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mips32_mem_arbiter_if.slave (requesters, core status, memory)
// Modes: LOAD (loader only, ld_done -> RUN), RUN (data over fetch unless fetch
// has been starved MAX_WAIT cycles; halted -> HALT), HALT (loader only,
// ld_req -> LOAD). Grants and the memory command are combinational; the
// per-requester read-valid pulses one cycle after a read grant.
// -----------------------------------------------------------------------------
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input logic                 clk,
  input logic                 reset,
  mips32_mem_arbiter_if.slave bus
);

  mode_e         state_q, state_d;
  logic          ld_gnt, if_gnt, dm_gnt;
  logic          starve_max, cnt_inc, cnt_clr;
  logic          rd_pend_q, rd_pend_d;
  req_id_e       rd_id_q, rd_id_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  // ---------------------------------------------------------------- state reg
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  // NOTE: each combinational output is given a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (bus.ld_done) state_d = RUN;
      RUN:     if (bus.halted)  state_d = HALT;
      HALT:    if (bus.ld_req)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // ------------------------------------------------------------------- grants
  // Reset forces every grant (and therefore the memory command) low.
  always_comb begin
    ld_gnt = 1'b0;
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        LOAD, HALT: ld_gnt = bus.ld_req;
        RUN: begin
          if (bus.if_req && (starve_max || !bus.dm_req)) if_gnt = 1'b1;
          else if (bus.dm_req)                           dm_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_gnt = ld_gnt;
  assign bus.if_gnt = if_gnt;
  assign bus.dm_gnt = dm_gnt;

  // ---------------------------------------------------------- memory command
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (ld_gnt) begin
      mem_we_d    = bus.ld_we;
      mem_addr_d  = bus.ld_addr;
      mem_wdata_d = bus.ld_wdata;
    end else if (dm_gnt) begin
      mem_we_d    = bus.dm_we;
      mem_addr_d  = bus.dm_addr;
      mem_wdata_d = bus.dm_wdata;
    end else if (if_gnt) begin
      mem_addr_d  = bus.if_addr;
    end
  end

  assign bus.mem_en    = ld_gnt | if_gnt | dm_gnt;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;

  // --------------------------------------------------------- read-valid steer
  // Remember who received a read grant so the data returning next cycle is
  // flagged to that requester only; writes produce no valid pulse.
  always_comb begin
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (ld_gnt && !bus.ld_we) begin
      rd_pend_d = 1'b1;
      rd_id_d   = REQ_LD;
    end else if (if_gnt) begin
      rd_pend_d = 1'b1;
      rd_id_d   = REQ_IF;
    end else if (dm_gnt && !bus.dm_we) begin
      rd_pend_d = 1'b1;
      rd_id_d   = REQ_DM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= REQ_LD;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign bus.ld_rvalid = rd_pend_q && (rd_id_q == REQ_LD);
  assign bus.if_rvalid = rd_pend_q && (rd_id_q == REQ_IF);
  assign bus.dm_rvalid = rd_pend_q && (rd_id_q == REQ_DM);
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mode      = state_q;

  // ------------------------------------------------------ fetch starvation
  // Cleared on the edge that leaves RUN as well as while outside it, so a
  // denied fetch on the halting edge does not carry a stale count.
  assign cnt_inc = (state_q == RUN) && bus.if_req && !if_gnt;
  assign cnt_clr = if_gnt || (state_q != RUN) || (state_d != RUN);

  mips32_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (cnt_inc),
    .clr_i    (cnt_clr),
    .at_max_o (starve_max)
  );

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips32_mem_arbiter
// Directed bench for mips32_mem_arbiter with a 1024-word synchronous memory
// attached. A behavioural model (mode as an integer, starvation as a wait
// count, a reference memory and a one-deep pending-read record) is checked
// against the DUT every falling edge; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_mips32_mem_arbiter;

  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  localparam int W_NONE = 0;
  localparam int W_LD   = 1;
  localparam int W_IF   = 2;
  localparam int W_DM   = 3;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic reset;
  bit   chk_en;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory array, one-cycle read latency.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] mem_rdata_q;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem_rdata_q = '0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_q <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rdata = mem_rdata_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2:0] gnt_vec(input int who);
    case (who)
      W_LD:    return 3'b100;
      W_IF:    return 3'b010;
      W_DM:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------------------------------------------------------- model
  int            m_mode;
  int            m_wait;
  bit            m_pend;
  int            m_pend_who;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] ref_mem [0:1023];

  initial begin : compare
    int            e_who;
    bit            e_we;
    int            e_addr;
    logic [DW-1:0] e_wdata;
    m_mode = M_LOAD;
    m_wait = 0;
    m_pend = 1'b0;
    m_pend_who = W_NONE;
    m_pend_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (reset) begin
          check("rst_gnt", {bus.ld_gnt, bus.if_gnt, bus.dm_gnt}, 0);
          check("rst_mem_en", bus.mem_en, 0);
          check("rst_rvalid", {bus.ld_rvalid, bus.if_rvalid, bus.dm_rvalid}, 0);
          check("rst_mode", bus.mode, M_LOAD);
          m_mode = M_LOAD;
          m_wait = 0;
          m_pend = 1'b0;
        end else begin
          // Who must own the memory this cycle.
          e_who = W_NONE;
          if (m_mode == M_RUN) begin
            if (bus.if_req && (!bus.dm_req || m_wait >= MAX_WAIT)) e_who = W_IF;
            else if (bus.dm_req)                                   e_who = W_DM;
          end else if (bus.ld_req) begin
            e_who = W_LD;
          end
          e_we = 1'b0; e_addr = 0; e_wdata = '0;
          case (e_who)
            W_LD: begin e_we = bus.ld_we; e_addr = int'(bus.ld_addr); e_wdata = bus.ld_wdata; end
            W_IF: begin e_addr = int'(bus.if_addr); end
            W_DM: begin e_we = bus.dm_we; e_addr = int'(bus.dm_addr); e_wdata = bus.dm_wdata; end
            default: ;
          endcase

          check("gnt", {bus.ld_gnt, bus.if_gnt, bus.dm_gnt}, gnt_vec(e_who));
          check("mem_en", bus.mem_en, (e_who != W_NONE));
          check("mode", bus.mode, m_mode);
          check("rvalid", {bus.ld_rvalid, bus.if_rvalid, bus.dm_rvalid},
                m_pend ? gnt_vec(m_pend_who) : 3'b000);
          if (m_pend) check("rdata", bus.rdata, m_pend_data);
          if (e_who != W_NONE) begin
            check("mem_we", bus.mem_we, e_we);
            check("mem_addr", bus.mem_addr, e_addr);
            if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
          end

          // Advance the model across the coming rising edge.
          m_pend = 1'b0;
          if (e_who != W_NONE) begin
            if (e_we) ref_mem[e_addr] = e_wdata;
            else begin
              m_pend      = 1'b1;
              m_pend_who  = e_who;
              m_pend_data = ref_mem[e_addr];
            end
          end
          if (m_mode == M_RUN) begin
            if (e_who == W_IF)    m_wait = 0;
            else if (bus.if_req)  m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
          end
          case (m_mode)
            M_LOAD: if (bus.ld_done) m_mode = M_RUN;
            M_RUN:  if (bus.halted)  m_mode = M_HALT;
            M_HALT: if (bus.ld_req)  m_mode = M_LOAD;
            default: m_mode = M_LOAD;
          endcase
          if (m_mode != M_RUN) m_wait = 0;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] prog [0:8];

  initial begin : stim
    prog = '{32'h2801000a, 32'h24020005, 32'h00221820, 32'h0ce77800, 32'hac030014,
             32'h8c040005, 32'h00000000, 32'h1000ffff, 32'hfc000000};
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_done = 0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.halted = 0;
    reset = 1'b0;
    chk_en = 1'b0;

    #2 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_mode_load", bus.mode, 0);
    next_cycle();
    reset = 1'b0;

    // Program load; fetch and data keep requesting and must stay ungranted.
    for (int i = 0; i < 9; i++) begin
      bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = AW'(i); bus.ld_wdata = prog[i];
      bus.if_req = 1; bus.if_addr = '0;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = AW'(5);
      @(negedge clk);
      check("load_ld_gnt", bus.ld_gnt, 1);
      check("load_if_gnt_held", bus.if_gnt, 0);
      next_cycle();
    end
    // Loader read of addr 0 together with ld_done.
    bus.ld_we = 0; bus.ld_addr = '0; bus.ld_done = 1;
    bus.if_req = 0; bus.dm_req = 0;
    @(negedge clk);
    check("done_ld_gnt", bus.ld_gnt, 1);
    next_cycle();
    bus.ld_req = 0; bus.ld_done = 0;
    @(negedge clk);
    check("done_ld_rvalid", bus.ld_rvalid, 1);
    check("done_rdata", bus.rdata, 32'h2801000a);
    check("done_mode_run", bus.mode, 1);
    next_cycle();

    // Starvation: data wins MAX_WAIT times, then fetch is promoted.
    bus.if_req = 1; bus.if_addr = '0;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = AW'(5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        check("starve_dm_gnt", bus.dm_gnt, 1);
        check("starve_if_held", bus.if_gnt, 0);
      end else begin
        check("starve_if_promoted", bus.if_gnt, 1);
        check("starve_dm_held", bus.dm_gnt, 0);
      end
      if (c >= 2) begin
        check("starve_dm_rvalid", bus.dm_rvalid, 1);
        check("starve_rdata", bus.rdata, 32'h8c040005);
      end
      next_cycle();
    end
    // Counter cleared: data wins again; loader and ld_done ignored in RUN.
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_done = 1;
    @(negedge clk);
    check("post_if_rvalid", bus.if_rvalid, 1);
    check("post_rdata", bus.rdata, 32'h2801000a);
    check("post_dm_gnt", bus.dm_gnt, 1);
    check("run_ld_gnt_ignored", bus.ld_gnt, 0);
    next_cycle();
    bus.ld_req = 0; bus.ld_done = 0; bus.if_req = 0; bus.dm_req = 0;
    @(negedge clk);
    check("run_mode_kept", bus.mode, 1);
    next_cycle();

    // Single fetch of addr 3.
    bus.if_req = 1; bus.if_addr = AW'(3);
    @(negedge clk);
    check("fetch3_gnt", bus.if_gnt, 1);
    next_cycle();
    bus.if_req = 0;
    @(negedge clk);
    check("fetch3_rvalid", bus.if_rvalid, 1);
    check("fetch3_rdata", bus.rdata, 32'h0ce77800);
    check("fetch3_others", {bus.ld_rvalid, bus.dm_rvalid}, 0);
    next_cycle();

    // Data write to addr 20, then fetch it back.
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = AW'(20); bus.dm_wdata = 32'hdeadbeef;
    @(negedge clk);
    check("wr20_gnt", bus.dm_gnt, 1);
    check("wr20_mem_we", bus.mem_we, 1);
    next_cycle();
    bus.dm_req = 0; bus.dm_we = 0;
    bus.if_req = 1; bus.if_addr = AW'(20);
    @(negedge clk);
    check("wr20_no_rvalid", {bus.ld_rvalid, bus.if_rvalid, bus.dm_rvalid}, 0);
    check("rd20_gnt", bus.if_gnt, 1);
    next_cycle();
    bus.if_req = 0;
    @(negedge clk);
    check("rd20_rvalid", bus.if_rvalid, 1);
    check("rd20_rdata", bus.rdata, 32'hdeadbeef);
    next_cycle();

    // Halt, ignore core requests, reload, resume.
    bus.halted = 1;
    @(negedge clk);
    check("halt_edge_mode_run", bus.mode, 1);
    next_cycle();
    bus.if_req = 1; bus.if_addr = AW'(3);
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = AW'(5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("halt_mode", bus.mode, 2);
      check("halt_core_gnt", {bus.if_gnt, bus.dm_gnt}, 0);
      next_cycle();
    end
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = AW'(3);
    @(negedge clk);
    check("halt_ld_gnt", bus.ld_gnt, 1);
    next_cycle();
    bus.ld_req = 0; bus.ld_done = 1; bus.halted = 0;
    @(negedge clk);
    check("reload_mode_load", bus.mode, 0);
    check("reload_ld_rvalid", bus.ld_rvalid, 1);
    check("reload_rdata", bus.rdata, 32'h0ce77800);
    check("reload_core_gnt", {bus.if_gnt, bus.dm_gnt}, 0);
    next_cycle();
    bus.ld_done = 0;
    @(negedge clk);
    check("resume_mode_run", bus.mode, 1);
    check("resume_dm_gnt", bus.dm_gnt, 1);
    next_cycle();
    bus.if_req = 0; bus.dm_req = 0;

    // Reset in the cycle after a read grant.
    bus.if_req = 1; bus.if_addr = AW'(3);
    @(negedge clk);
    check("prerst_if_gnt", bus.if_gnt, 1);
    next_cycle();
    bus.if_req = 0;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = AW'(5);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_if_rvalid", bus.if_rvalid, 0);
    check("midrst_mode", bus.mode, 0);
    check("midrst_gnt", {bus.ld_gnt, bus.if_gnt, bus.dm_gnt}, 0);
    check("midrst_mem_en", bus.mem_en, 0);
    next_cycle();
    reset = 1'b0;
    bus.dm_req = 0;
    @(negedge clk);
    check("afterrst_mode", bus.mode, 0);
    check("afterrst_rvalid", {bus.ld_rvalid, bus.if_rvalid, bus.dm_rvalid}, 0);
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. It shares one synchronous instruction/data memory between three requesters: the program loader, instruction fetch (IF stage), and data access (MEM stage, LW/SW). It sequences load mode, run mode and halt mode, and guarantees fetch forward progress under sustained data traffic. It sits between the core's IF/MEM stages and the memory array.

## Interface
- AW, 10, word-address width
- DW, 32, data width
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is promoted over data (≥1)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- ld_req / ld_we / ld_addr / ld_wdata  in  1/1/AW/DW  loader request
- ld_done  in  1  one-cycle pulse: program load complete
- ld_gnt / ld_rvalid  out  1/1  loader grant / read data valid
- if_req / if_addr  in  1/AW  fetch request (read only)
- if_gnt / if_rvalid  out  1/1  fetch grant / read data valid
- dm_req / dm_we / dm_addr / dm_wdata  in  1/1/AW/DW  data request
- dm_gnt / dm_rvalid  out  1/1  data grant / read data valid
- halted  in  1  core HALTED flag
- rdata  out  DW  shared read data, equals mem_rdata
- mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  memory command
- mem_rdata  in  DW  memory read data, 1-cycle latency
- mode  out  2  current state (LOAD/RUN/HALT)

## Operation
- FSM states: LOAD, RUN, HALT. Reset value: LOAD.
- LOAD: only loader may be granted; if/dm gnt held 0. ld_done → RUN.
- RUN: priority dm > if, except when starve counter == MAX_WAIT, then if > dm. halted=1 → HALT (same edge; grants in that cycle still honoured). Loader requests ignored in RUN.
- HALT: only loader granted; ld_req=1 → LOAD.
- ld_done while not in LOAD: ignored. ld_done and ld_req in the same cycle in LOAD: ld_req granted, then → RUN.
- At most one gnt per cycle. Requester holds req/addr/we/wdata stable until gnt seen.
- Starve counter: width clog2(MAX_WAIT+1); in RUN increments (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0; cleared on if_gnt, on leaving RUN, and on reset.
- Write grant: memory written at the grant edge; no rvalid.
- Read grant: the matching *_rvalid pulses exactly one cycle later, with rdata valid then.
- Reset mid-operation: all rvalid clear immediately; any pending read is discarded; counter 0; state LOAD.

## Timing
- gnt, mem_en, mem_we, mem_addr, mem_wdata: combinational from req inputs and registered state; mem_en = OR of gnts.
- *_rvalid registered; reset value 0. mode registered; reset value LOAD. All gnt and mem_* outputs are 0 while reset is asserted.
- Read latency: grant in cycle N → rvalid/rdata in cycle N+1. Back-to-back reads are allowed every cycle; throughput is 1 access/cycle.
- State transitions take effect the cycle after the triggering input.

## Structure
- Shared package mips32_pkg: mode enum (LOAD=0, RUN=1, HALT=2) and requester-ID enum (REQ_LD, REQ_IF, REQ_DM), used for the registered "last read grant" that steers rvalid.
- One sub-module: mips32_starve_cnt (saturating counter, inputs inc/clr, output at_max).

## Test plan
- Reset, load Mem[0..8] via loader (e.g. 32'h2801000a at addr 0), pulse ld_done → mode=RUN; if_gnt held 0 while in LOAD.
- RUN, if_req and dm_req (read addr 5) both held, MAX_WAIT=4 → dm granted for 4 cycles, then if granted in cycle 5; counter cleared; dm_rvalid one cycle after each dm grant.
- Single fetch read addr 3 → if_gnt in cycle N, if_rvalid=1 and rdata=32'h0ce77800 in N+1, nothing else valid.
- dm write addr 20 = 32'hdeadbeef, then fetch addr 20 → rdata 32'hdeadbeef; no rvalid for the write.
- halted=1 in RUN → HALT; if_req/dm_req never granted; ld_req → LOAD, then ld_done → RUN.
- Assert reset the cycle after a read grant → no rvalid, mode=LOAD, all gnt=0.
